// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receiver: FSM states, err bit
// positions, frame length and the odd-parity check.
package ps2_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_e;

    localparam int ERR_PAR    = 0;
    localparam int ERR_FRM    = 1;
    localparam int ERR_TMO    = 2;
    localparam int FRAME_BITS = 11;

    // Odd parity: the data bits together with the parity bit hold an odd number of ones.
    function automatic logic parity_ok(input logic [7:0] byte_in, input logic par);
        return ^{par, byte_in};
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Pin synchronisers for ps2_clk/ps2_data and the one-cycle strobe that marks
// a synchronised falling edge of ps2_clk.
module ps2_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic clrn,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic data_s,
    output logic sample
);

    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
    logic                   clk_prev_q, clk_prev_d;

    always_comb begin
        clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
        data_sync_d = {data_sync_q[SYNC_STAGES-2:0], ps2_data};
        clk_prev_d  = clk_sync_q[SYNC_STAGES-1];
    end

    // Everything resets to 1 so an idle bus never produces a spurious edge.
    // NOTE: state is updated with <= so every flop samples the pre-edge values.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            clk_prev_q  <= clk_prev_d;
        end
    end

    assign data_s = data_sync_q[SYNC_STAGES-1];
    assign sample = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: deframes 11-bit frames, checks start/stop and
// odd parity, watches for stalled frames and queues good bytes in a FIFO.
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH          = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                       clk,
    input  logic                       clrn,
    input  logic                       ps2_clk,
    input  logic                       ps2_data,
    input  logic                       rdn,
    input  logic                       err_clr,
    output logic [7:0]                 data,
    output logic                       ready,
    output logic                       overflow,
    output logic [2:0]                 err,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);
    localparam int TW = $clog2(TIMEOUT_CYCLES+1);

    logic data_s, sample;

    ps2_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .clrn    (clrn),
        .ps2_clk (ps2_clk),
        .ps2_data(ps2_data),
        .data_s  (data_s),
        .sample  (sample)
    );

    state_e                  state_q, state_d;
    logic [3:0]              bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-3:0]   shift_q, shift_d;
    logic [TW-1:0]           tmo_q, tmo_d;
    logic [2:0]              err_q, err_d, err_set;
    logic                    overflow_q, overflow_d;
    logic [AW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]           level_q, level_d;
    logic [7:0]              mem_q [DEPTH];
    logic                    push_req, push, pop, full, ovf_set;
    logic [7:0]              push_byte;

    // Deframer. shift_q keeps data and parity; the stop bit is judged as it
    // arrives, so the byte is pushed on the very edge that registers it.
    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        tmo_d     = '0;
        err_set   = '0;
        push_req  = 1'b0;
        push_byte = shift_q[7:0];
        case (state_q)
            IDLE: begin
                if (sample && !data_s) begin
                    state_d   = RECV;
                    bit_cnt_d = 4'd1;
                end
            end
            RECV: begin
                if (sample) begin
                    if (bit_cnt_q == 4'(FRAME_BITS-1)) begin
                        state_d = IDLE;
                        if (!data_s)
                            err_set[ERR_FRM] = 1'b1;
                        else if (!parity_ok(shift_q[7:0], shift_q[8]))
                            err_set[ERR_PAR] = 1'b1;
                        else
                            push_req = 1'b1;
                    end else begin
                        shift_d   = {data_s, shift_q[FRAME_BITS-3:1]};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end else if (tmo_q == TW'(TIMEOUT_CYCLES)) begin
                    err_set[ERR_TMO] = 1'b1;
                    state_d          = IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO control. A pop frees the slot a same-cycle push into a full FIFO needs.
    always_comb begin
        pop        = !rdn && (level_q != '0);
        full       = (level_q == LW'(DEPTH));
        push       = push_req && (!full || pop);
        ovf_set    = push_req && full && !pop;
        wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d    = level_q;
        if (push && !pop)
            level_d = level_q + LW'(1);
        else if (pop && !push)
            level_d = level_q - LW'(1);
        overflow_d = ovf_set | (overflow_q & !pop);
        err_d      = err_set | (err_q & ~{3{err_clr}});
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            tmo_q      <= '0;
            err_q      <= '0;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tmo_q      <= tmo_d;
            err_q      <= err_d;
            overflow_q <= overflow_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
        end
    end

    // NOTE: storage has no reset; level_q alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= push_byte;
    end

    assign data     = mem_q[rd_ptr_q];
    assign ready    = (level_q != '0);
    assign level    = level_q;
    assign overflow = overflow_q;
    assign err      = err_q;
    assign busy     = (state_q == RECV);

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Self-checking bench for ps2_rx_fifo: directed table, corner sequences and
// random frames checked against a queue-based model of the receiver.
module tb_ps2_rx_fifo;

    localparam int DEPTH = 8;
    localparam int SYNC  = 2;
    localparam int TMO   = 300;
    localparam int HALF  = 20;

    logic       clk      = 1'b0;
    logic       clrn     = 1'b0;
    logic       ps2_clk  = 1'b1;
    logic       ps2_data = 1'b1;
    logic       rdn      = 1'b1;
    logic       err_clr  = 1'b0;
    logic [7:0] data;
    logic       ready, overflow, busy;
    logic [2:0] err;
    logic [$clog2(DEPTH+1)-1:0] level;

    int         n_vec = 0;
    int         n_bad = 0;

    logic [7:0] q[$];
    logic       m_ovf = 1'b0;
    logic [2:0] m_err = 3'b000;

    typedef struct {
        logic [7:0] b;
        logic       par_flip;
        logic       stop;
        logic [2:0] exp_err;
        int         exp_level;
    } vec_t;

    vec_t vecs[5];

    always #5 clk = ~clk;

    ps2_rx_fifo #(
        .DEPTH         (DEPTH),
        .SYNC_STAGES   (SYNC),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk     (clk),
        .clrn    (clrn),
        .ps2_clk (ps2_clk),
        .ps2_data(ps2_data),
        .rdn     (rdn),
        .err_clr (err_clr),
        .data    (data),
        .ready   (ready),
        .overflow(overflow),
        .err     (err),
        .level   (level),
        .busy    (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] frame_word(input logic [7:0] b, input logic pf, input logic stop);
        return {stop, (~^b) ^ pf, b, 1'b0};
    endfunction

    // Bit-bangs the first nbits of a frame; optionally pulls rdn low for the
    // single cycle in which the stop-bit sample is registered.
    task automatic send_bits(input logic [10:0] frame, input int nbits, input bit pop_at_stop);
        for (int i = 0; i < nbits; i++) begin
            @(posedge clk); #1 ps2_data = frame[i];
            repeat (HALF-1) @(posedge clk);
            #1 ps2_clk = 1'b0;
            if (pop_at_stop && i == 10) begin
                repeat (SYNC) @(posedge clk);
                #1 rdn = 1'b0;
                @(posedge clk); #1 rdn = 1'b1;
                repeat (HALF-SYNC-1) @(posedge clk);
            end else begin
                repeat (HALF) @(posedge clk);
            end
            #1 ps2_clk = 1'b1;
        end
        repeat (4) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_frame(input logic [7:0] b, input logic pf, input logic stop);
        if (!stop)                 m_err[1] = 1'b1;
        else if (pf)               m_err[0] = 1'b1;
        else if (q.size() == DEPTH) m_ovf   = 1'b1;
        else                       q.push_back(b);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic pf, input logic stop);
        send_bits(frame_word(b, pf, stop), 11, 1'b0);
        model_frame(b, pf, stop);
    endtask

    task automatic pop_one();
        @(posedge clk); #1 rdn = 1'b0;
        @(posedge clk); #1 rdn = 1'b1;
        @(negedge clk);
        if (q.size() > 0) begin
            void'(q.pop_front());
            m_ovf = 1'b0;
        end
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1 err_clr = 1'b1;
        @(posedge clk); #1 err_clr = 1'b0;
        @(negedge clk);
        m_err = 3'b000;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_ready"},    32'(ready),    32'(q.size() != 0));
        check({tag, "_level"},    32'(level),    32'(q.size()));
        check({tag, "_overflow"}, 32'(overflow), 32'(m_ovf));
        check({tag, "_err"},      32'(err),      32'(m_err));
        check({tag, "_busy"},     32'(busy),     32'd0);
        if (q.size() > 0)
            check({tag, "_data"}, 32'(data), 32'(q[0]));
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ready"},    32'(ready),    32'd0);
        check({tag, "_level"},    32'(level),    32'd0);
        check({tag, "_overflow"}, 32'(overflow), 32'd0);
        check({tag, "_err"},      32'(err),      32'd0);
        check({tag, "_busy"},     32'(busy),     32'd0);
    endtask

    initial begin
        vecs[0] = '{8'h1C, 1'b0, 1'b1, 3'b000, 1};
        vecs[1] = '{8'hA5, 1'b1, 1'b0, 3'b010, 1};
        vecs[2] = '{8'h1C, 1'b1, 1'b1, 3'b011, 1};
        vecs[3] = '{8'h00, 1'b0, 1'b1, 3'b011, 2};
        vecs[4] = '{8'h80, 1'b0, 1'b1, 3'b011, 3};

        repeat (3) @(posedge clk);
        #1 clrn = 1'b1;
        @(negedge clk);
        check_reset("reset");

        // Good byte, then a single pop.
        send_frame(8'h1C, 1'b0, 1'b1);
        check("t1_ready", 32'(ready), 32'd1);
        check("t1_level", 32'(level), 32'd1);
        check("t1_data",  32'(data),  32'h1C);
        check("t1_err",   32'(err),   32'd0);
        pop_one();
        check("t1_pop_ready", 32'(ready), 32'd0);
        check("t1_pop_level", 32'(level), 32'd0);

        // Parity error, then clear.
        send_frame(8'h1C, 1'b1, 1'b1);
        check("t2_err",   32'(err),   32'b001);
        check("t2_level", 32'(level), 32'd0);
        pulse_clr();
        check("t2_clr_err", 32'(err), 32'd0);

        // Table: stop error outranks parity, errors stay sticky.
        for (int i = 0; i < 5; i++) begin
            send_frame(vecs[i].b, vecs[i].par_flip, vecs[i].stop);
            check($sformatf("tab%0d_err", i),   32'(err),   32'(vecs[i].exp_err));
            check($sformatf("tab%0d_level", i), 32'(level), 32'(vecs[i].exp_level));
        end
        pulse_clr();
        while (q.size() > 0) begin
            check("tab_drain_data", 32'(data), 32'(q[0]));
            pop_one();
        end
        check_model("tab_drained");

        // Overflow: nine bytes into eight entries.
        for (int b = 1; b <= 9; b++) send_frame(8'(b), 1'b0, 1'b1);
        check("ovf_level", 32'(level),    32'd8);
        check("ovf_flag",  32'(overflow), 32'd1);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("ovf_pop%0d_data", i), 32'(data), 32'(i + 1));
            pop_one();
            if (i == 0) check("ovf_cleared", 32'(overflow), 32'd0);
        end
        check_model("ovf_drained");

        // Watchdog aborts a stalled frame; the next frame is intact.
        send_bits(frame_word(8'h35, 1'b0, 1'b1), 5, 1'b0);
        check("tmo_busy_mid", 32'(busy), 32'd1);
        repeat (200) @(posedge clk);
        @(negedge clk);
        check("tmo_not_early_busy", 32'(busy), 32'd1);
        check("tmo_not_early_err",  32'(err),  32'd0);
        repeat (TMO) @(posedge clk);
        @(negedge clk);
        m_err[2] = 1'b1;
        check("tmo_err",  32'(err),  32'b100);
        check("tmo_busy", 32'(busy), 32'd0);
        pulse_clr();
        send_frame(8'hF0, 1'b0, 1'b1);
        check_model("tmo_next");
        pop_one();

        // Full FIFO with a pop coinciding with the stop-bit sample.
        for (int b = 0; b < 9; b++) send_frame(8'(8'h40 + b), 1'b0, 1'b1);
        check_model("full_pre");
        send_bits(frame_word(8'hC3, 1'b0, 1'b1), 11, 1'b1);
        void'(q.pop_front());
        m_ovf = 1'b0;
        q.push_back(8'hC3);
        check("full_pop_level", 32'(level),    32'd8);
        check("full_pop_ovf",   32'(overflow), 32'd0);
        check("full_pop_data",  32'(data),     32'h41);
        while (q.size() > 0) begin
            check("full_drain_data", 32'(data), 32'(q[0]));
            pop_one();
        end

        // Reset in the middle of a frame.
        send_frame(8'h11, 1'b0, 1'b1);
        send_frame(8'h22, 1'b1, 1'b1);
        check_model("rst_pre");
        send_bits(frame_word(8'h99, 1'b0, 1'b1), 6, 1'b0);
        check("rst_busy_mid", 32'(busy), 32'd1);
        @(posedge clk); #1 clrn = 1'b0;
        @(negedge clk);
        check_reset("rst_held");
        repeat (3) @(posedge clk);
        #1 clrn = 1'b1;
        @(negedge clk);
        check_reset("rst_released");
        q.delete();
        m_ovf = 1'b0;
        m_err = 3'b000;
        send_frame(8'h5A, 1'b0, 1'b1);
        check("rst_next_data", 32'(data), 32'h5A);
        check_model("rst_next");
        pop_one();

        // Random frames, pops and clears against the model.
        for (int n = 0; n < 20; n++) begin
            logic [7:0] b;
            int         c;
            int         npop;
            b = 8'($urandom);
            c = $urandom_range(0, 9);
            send_frame(b, c == 0, c != 1);
            check_model($sformatf("rnd%0d_frame", n));
            npop = $urandom_range(0, 2);
            for (int k = 0; k < npop; k++) pop_one();
            if ($urandom_range(0, 3) == 0) pulse_clr();
            check_model($sformatf("rnd%0d_after", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
